// File: rtl/traffic_pkg.sv
// Shared state encoding and lamp constants for the intersection phase controller.
// FLASH is always encoded; it is only reachable when built with NIGHT_FLASH_EN.
package traffic_pkg;
  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALL_RED_1   = 3'd2,
    SIDE_GREEN  = 3'd3,
    SIDE_YELLOW = 3'd4,
    ALL_RED_2   = 3'd5,
    FLASH       = 3'd6
  } state_t;

  localparam logic [2:0] LAMP_R   = 3'b100;
  localparam logic [2:0] LAMP_Y   = 3'b010;
  localparam logic [2:0] LAMP_G   = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;
endpackage

// File: rtl/phase_timer.sv
// Tick-enabled phase timer; saturates at the last count of the current phase.
// done flags the final tick of the phase (count == duration-1).
module phase_timer #(
  parameter int TIMER_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               tick,
  input  logic [TIMER_W-1:0] limit,
  output logic               done
);
  logic [TIMER_W-1:0] cnt_q;

  assign done = (cnt_q == limit);

  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt_q <= '0;
    else if (tick && !done)
      cnt_q <= cnt_q + 1'b1;
  end
endmodule

// File: rtl/traffic_phase_fsm.sv
// Main/side road phase sequencer driven by a 1 Hz tick, Moore lamp outputs.
// Optional night flashing mode is built in with NIGHT_FLASH_EN.
module traffic_phase_fsm
  import traffic_pkg::*;
#(
  parameter int MAIN_GREEN_S = 20,
  parameter int SIDE_GREEN_S = 10,
  parameter int YELLOW_S     = 3,
  parameter int ALL_RED_S    = 1,
  parameter int TIMER_W      = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       side_req,
  input  logic       night_mode,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic [2:0] phase
);
  state_t state_q, state_d;
  logic req_q, req_d;
  logic t_done;
  logic [TIMER_W-1:0] limit;
  logic entering_sg;

  phase_timer #(.TIMER_W(TIMER_W)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_d != state_q),
    .tick (tick),
    .limit(limit),
    .done (t_done)
  );

  always_comb begin
    limit = '0;
    case (state_q)
      MAIN_GREEN:  limit = TIMER_W'(MAIN_GREEN_S - 1);
      MAIN_YELLOW,
      SIDE_YELLOW: limit = TIMER_W'(YELLOW_S - 1);
      SIDE_GREEN:  limit = TIMER_W'(SIDE_GREEN_S - 1);
      ALL_RED_1,
      ALL_RED_2:   limit = TIMER_W'(ALL_RED_S - 1);
      default:     limit = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    if (tick) begin
      case (state_q)
        MAIN_GREEN:  if (t_done && req_q) state_d = MAIN_YELLOW;
        MAIN_YELLOW: if (t_done) state_d = ALL_RED_1;
        ALL_RED_1:   if (t_done) state_d = SIDE_GREEN;
        SIDE_GREEN:  if (t_done) state_d = SIDE_YELLOW;
        SIDE_YELLOW: if (t_done) state_d = ALL_RED_2;
        ALL_RED_2:   if (t_done) state_d = MAIN_GREEN;
        default:     state_d = MAIN_GREEN;
      endcase
`ifdef NIGHT_FLASH_EN
      if (night_mode)
        state_d = FLASH;
      else if (state_q == FLASH)
        state_d = ALL_RED_2;
`endif
    end
  end

  // Entry into side green consumes the request, even against a new one.
  assign entering_sg = (state_d == SIDE_GREEN) && (state_q != SIDE_GREEN);

  always_comb begin
    req_d = req_q;
    if (entering_sg)
      req_d = 1'b0;
    else if (side_req && state_q != SIDE_GREEN)
      req_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MAIN_GREEN;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
    end
  end

`ifdef NIGHT_FLASH_EN
  logic flash_q;

  always_ff @(posedge clk) begin
    if (rst)
      flash_q <= 1'b0;
    else if (state_d == FLASH && state_q != FLASH)
      flash_q <= 1'b0;
    else if (state_q == FLASH && tick)
      flash_q <= ~flash_q;
  end
`else
  logic unused_night;
  assign unused_night = night_mode;
`endif

  always_comb begin
    main_light = LAMP_R;
    side_light = LAMP_R;
    case (state_q)
      MAIN_GREEN:  main_light = LAMP_G;
      MAIN_YELLOW: main_light = LAMP_Y;
      SIDE_GREEN:  side_light = LAMP_G;
      SIDE_YELLOW: side_light = LAMP_Y;
`ifdef NIGHT_FLASH_EN
      FLASH: begin
        main_light = flash_q ? LAMP_Y : LAMP_OFF;
        side_light = flash_q ? LAMP_R : LAMP_OFF;
      end
`endif
      default: ;
    endcase
  end

  assign phase = state_q;
endmodule

// File: tb/tb_traffic_phase_fsm.sv
// Directed, table-driven bench for traffic_phase_fsm.
// Covers NIGHT_FLASH_EN behaviour when built with that macro.
module tb_traffic_phase_fsm;
  import traffic_pkg::*;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] O = 3'b000;

  localparam logic [2:0] P_MG  = 3'd0;
  localparam logic [2:0] P_MY  = 3'd1;
  localparam logic [2:0] P_AR1 = 3'd2;
  localparam logic [2:0] P_SG  = 3'd3;
  localparam logic [2:0] P_SY  = 3'd4;
  localparam logic [2:0] P_AR2 = 3'd5;
  localparam logic [2:0] P_FL  = 3'd6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  logic side_req = 1'b0;
  logic night_mode = 1'b0;
  logic [2:0] main_light, side_light, phase;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int         n;
    bit         tk;
    bit         rq;
    logic [2:0] ph;
    logic [2:0] ml;
    logic [2:0] sl;
  } vec_t;

  vec_t vq[$];

  traffic_phase_fsm dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .side_req  (side_req),
    .night_mode(night_mode),
    .main_light(main_light),
    .side_light(side_light),
    .phase     (phase)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [2:0] act, logic [2:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk3(string nm, logic [2:0] ph, logic [2:0] ml,
                      logic [2:0] sl);
    chk({nm, "_phase"}, phase, ph);
    chk({nm, "_main"}, main_light, ml);
    chk({nm, "_side"}, side_light, sl);
  endtask

  task automatic run(int n, bit tk, bit rq);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tick = tk;
      side_req = rq;
      @(posedge clk);
      #1;
      tick = 1'b0;
      side_req = 1'b0;
    end
  endtask

  task automatic add(int n, bit tk, bit rq, logic [2:0] ph,
                     logic [2:0] ml, logic [2:0] sl);
    vec_t v;
    v.n = n; v.tk = tk; v.rq = rq;
    v.ph = ph; v.ml = ml; v.sl = sl;
    vq.push_back(v);
  endtask

  initial begin
    // idle: no request for 30 ticks, timer saturates
    add(30, 1, 0, P_MG, G, R);
    add(1, 0, 1, P_MG, G, R);
    add(1, 1, 0, P_MY, Y, R);
    add(2, 1, 0, P_MY, Y, R);
    add(1, 1, 0, P_AR1, R, R);
    add(1, 1, 0, P_SG, R, G);
    add(9, 1, 0, P_SG, R, G);
    add(1, 1, 0, P_SY, R, Y);
    add(2, 1, 0, P_SY, R, Y);
    add(1, 1, 0, P_AR2, R, R);
    add(1, 1, 0, P_MG, G, R);
    // request pulse with the 5th tick; exit on the 20th
    add(4, 1, 0, P_MG, G, R);
    add(1, 1, 1, P_MG, G, R);
    add(14, 1, 0, P_MG, G, R);
    add(1, 1, 0, P_MY, Y, R);
    add(3, 1, 0, P_AR1, R, R);
    add(1, 1, 1, P_SG, R, G);
    add(10, 1, 1, P_SY, R, Y);
    add(3, 1, 0, P_AR2, R, R);
    add(1, 1, 0, P_MG, G, R);
    add(25, 1, 0, P_MG, G, R);
    // request latched again in SIDE_YELLOW
    add(1, 0, 1, P_MG, G, R);
    add(1, 1, 0, P_MY, Y, R);
    add(3, 1, 0, P_AR1, R, R);
    add(1, 1, 0, P_SG, R, G);
    add(10, 1, 1, P_SY, R, Y);
    add(1, 0, 1, P_SY, R, Y);
    add(3, 1, 0, P_AR2, R, R);
    add(1, 1, 0, P_MG, G, R);
    add(19, 1, 0, P_MG, G, R);
    add(1, 1, 0, P_MY, Y, R);
    // long tick-free stretch must not advance the timer
    add(1000, 0, 0, P_MY, Y, R);
    add(1, 1, 0, P_MY, Y, R);
    add(1, 1, 0, P_MY, Y, R);
    add(1, 1, 0, P_AR1, R, R);
    add(1, 1, 0, P_SG, R, G);
    add(3, 1, 0, P_SG, R, G);

    repeat (2) @(posedge clk);
    #1;
    chk3("reset", P_MG, G, R);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      run(vq[i].n, vq[i].tk, vq[i].rq);
      chk3($sformatf("vec%0d", i), vq[i].ph, vq[i].ml, vq[i].sl);
    end

    // reset mid-SIDE_GREEN coincident with tick and request
    @(negedge clk);
    rst = 1'b1;
    tick = 1'b1;
    side_req = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick = 1'b0;
    side_req = 1'b0;
    chk3("rst_sg", P_MG, G, R);
    run(25, 1, 0);
    chk3("rst_noreq", P_MG, G, R);

`ifdef NIGHT_FLASH_EN
    run(1, 0, 1);
    run(1, 1, 0);
    run(3, 1, 0);
    run(1, 1, 0);
    chk3("fl_pre", P_SG, R, G);
    night_mode = 1'b1;
    run(1, 1, 0);
    chk3("fl_enter", P_FL, O, O);
    run(1, 1, 0);
    chk3("fl_on", P_FL, Y, R);
    run(1, 1, 0);
    chk3("fl_off", P_FL, O, O);
    night_mode = 1'b0;
    run(1, 1, 0);
    chk3("fl_exit", P_AR2, R, R);
    run(1, 1, 0);
    chk3("fl_main", P_MG, G, R);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
